// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS memory stage: 64x32 data memory with configurable latency feeding MEM/WB
module mem_stage #(
    parameter int MEM_LAT = 0,
    parameter int DEPTH   = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        WB_EXMEM,
    input  logic        M_EXMEM,
    input  logic [5:0]  Address_EXMEM,
    input  logic [31:0] Data_EXMEM,
    input  logic [4:0]  rw_EXMEM,
    input  logic        ForwardCtrl_EXMEM,
    output logic        WB_MEMWB,
    output logic [4:0]  rw_MEMWB,
    output logic [31:0] Data_MEMWB,
    output logic        ForwardCtrl_MEMWB,
    output logic        Stall_MEM
);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    localparam bit         ZERO_LAT = (MEM_LAT == 0);
    localparam logic [3:0] CNT_INIT = ZERO_LAT ? 4'd0 : 4'(MEM_LAT - 1);

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] mem_q [DEPTH];

    logic        wb_q, fwd_q;
    logic [4:0]  rw_q;
    logic [31:0] data_q;

    logic        wb_d, fwd_d;
    logic [4:0]  rw_d;
    logic [31:0] data_d;

    logic is_store, is_load, is_mem, complete;

    // A store wins over a simultaneous WB request: no write-back for it.
    assign is_store = M_EXMEM;
    assign is_load  = !M_EXMEM && WB_EXMEM;
    assign is_mem   = M_EXMEM || WB_EXMEM;

    assign complete = ((state_q == S_IDLE) && is_mem && ZERO_LAT) ||
                      ((state_q == S_BUSY) && (cnt_q == 4'd0));

    assign Stall_MEM = nRST && (((state_q == S_IDLE) && is_mem && !ZERO_LAT) ||
                                ((state_q == S_BUSY) && (cnt_q != 4'd0)));

    always_comb begin
        wb_d   = 1'b0;
        rw_d   = 5'd0;
        data_d = 32'd0;
        fwd_d  = 1'b0;
        if (complete && is_load) begin
            data_d = mem_q[Address_EXMEM];
            rw_d   = rw_EXMEM;
            // Register $0 is hardwired: never write it back or forward it.
            wb_d   = (rw_EXMEM != 5'd0);
            fwd_d  = ForwardCtrl_EXMEM && (rw_EXMEM != 5'd0);
        end
    end

    always_ff @(negedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wb_q    <= 1'b0;
            rw_q    <= 5'd0;
            data_q  <= 32'd0;
            fwd_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'd0;
            end
        end else begin
            wb_q   <= wb_d;
            rw_q   <= rw_d;
            data_q <= data_d;
            fwd_q  <= fwd_d;
            case (state_q)
                S_IDLE: begin
                    if (is_mem && !ZERO_LAT) begin
                        state_q <= S_BUSY;
                        cnt_q   <= CNT_INIT;
                    end
                end
                S_BUSY: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
            if (complete && is_store) begin
                mem_q[Address_EXMEM] <= Data_EXMEM;
            end
        end
    end

    assign WB_MEMWB          = wb_q;
    assign rw_MEMWB          = rw_q;
    assign Data_MEMWB        = data_q;
    assign ForwardCtrl_MEMWB = fwd_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage at latencies 0, 2 and 3
module tb_mem_stage;

    localparam int NL = 3;

    typedef struct packed {
        bit        wb;
        bit        m;
        bit [5:0]  a;
        bit [31:0] d;
        bit [4:0]  rw;
        bit        fwd;
    } op_t;

    typedef struct packed {
        bit        wb;
        bit [4:0]  rw;
        bit [31:0] d;
        bit        fwd;
    } out_t;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        wb_i [NL];
    logic        m_i [NL];
    logic [5:0]  a_i [NL];
    logic [31:0] d_i [NL];
    logic [4:0]  rw_i [NL];
    logic        fwd_i [NL];
    logic        wb_o [NL];
    logic [4:0]  rw_o [NL];
    logic [31:0] d_o [NL];
    logic        fwd_o [NL];
    logic        stall_o [NL];

    int checks = 0;
    int failures = 0;

    op_t       script_q [NL][$];
    out_t      out_q [NL][$];
    bit        stall_q [NL][$];
    op_t       cur [NL];
    bit        active [NL];
    int        stall_left [NL];
    bit [31:0] mem_m [NL][64];
    bit        rand_en = 1'b0;

    always #5 CLK = ~CLK;

    mem_stage #(.MEM_LAT(0)) u_lat0 (
        .CLK(CLK), .nRST(nRST), .WB_EXMEM(wb_i[0]), .M_EXMEM(m_i[0]),
        .Address_EXMEM(a_i[0]), .Data_EXMEM(d_i[0]), .rw_EXMEM(rw_i[0]),
        .ForwardCtrl_EXMEM(fwd_i[0]), .WB_MEMWB(wb_o[0]), .rw_MEMWB(rw_o[0]),
        .Data_MEMWB(d_o[0]), .ForwardCtrl_MEMWB(fwd_o[0]), .Stall_MEM(stall_o[0]));

    mem_stage #(.MEM_LAT(2)) u_lat2 (
        .CLK(CLK), .nRST(nRST), .WB_EXMEM(wb_i[1]), .M_EXMEM(m_i[1]),
        .Address_EXMEM(a_i[1]), .Data_EXMEM(d_i[1]), .rw_EXMEM(rw_i[1]),
        .ForwardCtrl_EXMEM(fwd_i[1]), .WB_MEMWB(wb_o[1]), .rw_MEMWB(rw_o[1]),
        .Data_MEMWB(d_o[1]), .ForwardCtrl_MEMWB(fwd_o[1]), .Stall_MEM(stall_o[1]));

    mem_stage #(.MEM_LAT(3)) u_lat3 (
        .CLK(CLK), .nRST(nRST), .WB_EXMEM(wb_i[2]), .M_EXMEM(m_i[2]),
        .Address_EXMEM(a_i[2]), .Data_EXMEM(d_i[2]), .rw_EXMEM(rw_i[2]),
        .ForwardCtrl_EXMEM(fwd_i[2]), .WB_MEMWB(wb_o[2]), .rw_MEMWB(rw_o[2]),
        .Data_MEMWB(d_o[2]), .ForwardCtrl_MEMWB(fwd_o[2]), .Stall_MEM(stall_o[2]));

    function automatic int lat_of(int l);
        case (l)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic op_t mk(bit wb, bit m, bit [5:0] a, bit [31:0] d, bit [4:0] rw, bit fwd);
        op_t o;
        o.wb = wb; o.m = m; o.a = a; o.d = d; o.rw = rw; o.fwd = fwd;
        return o;
    endfunction

    function automatic op_t rand_bubble();
        return mk(1'b0, 1'b0, 6'($urandom), $urandom, 5'($urandom), 1'($urandom));
    endfunction

    function automatic op_t rand_op();
        int  k;
        op_t o;
        k = $urandom_range(0, 9);
        o = rand_bubble();
        o.a = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
        o.rw = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
        if (k >= 3 && k < 6) begin
            o.m = 1'b1;
            o.wb = 1'($urandom_range(0, 1));
        end else if (k >= 6) begin
            o.wb = 1'b1;
        end
        return o;
    endfunction

    task automatic push_all(op_t o);
        for (int l = 0; l < NL; l++) script_q[l].push_back(o);
    endtask

    // Reference: an access occupies latency+1 cycles, stalling and emitting bubbles
    // for the first latency cycles, then completing on the last one.
    task automatic cycle();
        out_t e;
        @(posedge CLK);
        #1;
        for (int l = 0; l < NL; l++) begin
            if (!active[l]) begin
                if (script_q[l].size() > 0) cur[l] = script_q[l].pop_front();
                else if (rand_en) cur[l] = rand_op();
                else cur[l] = rand_bubble();
                active[l] = 1'b1;
                stall_left[l] = (cur[l].m || cur[l].wb) ? lat_of(l) : 0;
            end
            wb_i[l] = cur[l].wb; m_i[l] = cur[l].m; a_i[l] = cur[l].a;
            d_i[l] = cur[l].d; rw_i[l] = cur[l].rw; fwd_i[l] = cur[l].fwd;
            e = '0;
            if (stall_left[l] > 0) begin
                stall_q[l].push_back(1'b1);
                stall_left[l]--;
            end else begin
                stall_q[l].push_back(1'b0);
                if (cur[l].m) begin
                    mem_m[l][cur[l].a] = cur[l].d;
                end else if (cur[l].wb) begin
                    e.d = mem_m[l][cur[l].a];
                    e.rw = cur[l].rw;
                    e.wb = (cur[l].rw != 0);
                    e.fwd = cur[l].fwd && (cur[l].rw != 0);
                end
                active[l] = 1'b0;
            end
            out_q[l].push_back(e);
        end
    endtask

    function automatic bit busy_any();
        for (int l = 0; l < NL; l++)
            if (active[l] || script_q[l].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drain();
        int guard = 0;
        while (busy_any() && guard < 200) begin
            cycle();
            guard++;
        end
        checks++;
        if (guard >= 200) begin
            failures++;
            $display("FAIL drain: ops still pending after %0d cycles, required completion", guard);
        end
    endtask

    task automatic chk_out(int l, out_t e, string tag);
        out_t got;
        got = {wb_o[l], rw_o[l], d_o[l], fwd_o[l]};
        checks++;
        if (got !== e) begin
            failures++;
            $display("FAIL %s lane%0d: got wb=%0d rw=%0d data=%h fwd=%0d, required wb=%0d rw=%0d data=%h fwd=%0d",
                     tag, l, got.wb, got.rw, got.d, got.fwd, e.wb, e.rw, e.d, e.fwd);
        end
    endtask

    task automatic chk_stall(int l, bit e, string tag);
        checks++;
        if (stall_o[l] !== e) begin
            failures++;
            $display("FAIL %s lane%0d: Stall_MEM=%0d, required %0d", tag, l, stall_o[l], e);
        end
    endtask

    always @(negedge CLK) begin
        #1;
        for (int l = 0; l < NL; l++)
            if (out_q[l].size() > 0) chk_out(l, out_q[l].pop_front(), "memwb");
    end

    always @(posedge CLK) begin
        #3;
        for (int l = 0; l < NL; l++)
            if (stall_q[l].size() > 0) chk_stall(l, stall_q[l].pop_front(), "stall");
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int l = 0; l < NL; l++) begin
            wb_i[l] = 0; m_i[l] = 0; a_i[l] = 0; d_i[l] = 0; rw_i[l] = 0; fwd_i[l] = 0;
            active[l] = 0; stall_left[l] = 0;
            for (int i = 0; i < 64; i++) mem_m[l][i] = 0;
        end
        #13;
        for (int l = 0; l < NL; l++) begin
            chk_out(l, '0, "reset_out");
            chk_stall(l, 1'b0, "reset_stall");
        end
        #4 nRST = 1'b1;

        push_all(mk(1, 0, 6'h05, 32'h0, 5'd3, 1));
        push_all(mk(0, 1, 6'h3F, 32'hDEADBEEF, 5'd0, 0));
        push_all(mk(1, 0, 6'h3F, 32'h0, 5'd7, 1));
        push_all(mk(0, 1, 6'h10, 32'h12345678, 5'd2, 0));
        push_all(mk(1, 0, 6'h10, 32'h0, 5'd9, 0));
        push_all(mk(1, 0, 6'h10, 32'h0, 5'd0, 1));
        push_all(mk(1, 1, 6'h01, 32'hA5A5A5A5, 5'd4, 1));
        push_all(mk(1, 0, 6'h01, 32'h0, 5'd4, 1));
        for (int i = 0; i < 5; i++) push_all(rand_bubble());
        push_all(mk(1, 0, 6'h3F, 32'h0, 5'd31, 1));
        drain();

        rand_en = 1'b1;
        repeat (400) cycle();
        rand_en = 1'b0;
        drain();

        // Abort a multi-cycle store with reset while the slow lanes are still busy.
        push_all(mk(0, 1, 6'h20, 32'hCAFEF00D, 5'd0, 0));
        cycle();
        @(posedge CLK);
        #1 nRST = 1'b0;
        #1;
        for (int l = 0; l < NL; l++) begin
            chk_out(l, '0, "midreset_out");
            chk_stall(l, 1'b0, "midreset_stall");
            active[l] = 0;
            stall_left[l] = 0;
            out_q[l].delete();
            stall_q[l].delete();
            for (int i = 0; i < 64; i++) mem_m[l][i] = 0;
        end
        @(negedge CLK);
        #2 nRST = 1'b1;
        push_all(mk(1, 0, 6'h20, 32'h0, 5'd5, 1));
        push_all(mk(1, 0, 6'h3F, 32'h0, 5'd6, 1));
        drain();

        repeat (2) @(posedge CLK);
        #4;
        for (int l = 0; l < NL; l++) begin
            checks++;
            if (out_q[l].size() != 0 || stall_q[l].size() != 0) begin
                failures++;
                $display("FAIL scoreboard_empty lane%0d: %0d/%0d entries left, required 0/0",
                         l, out_q[l].size(), stall_q[l].size());
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory stage of the MIPS pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its WB, M, Address, Data, rw and ForwardCtrl fields.
- Contains a 64x32 data memory with a configurable access latency.
- Drives the MEM/WB pipeline register that feeds write-back and the forwarding unit.
- Raises a stall to the hazard unit while a multi-cycle access is in flight.

Parameters:
- MEM_LAT, 0, extra wait cycles per memory access (0 = single-cycle access; legal range 0..15).
- DEPTH, 64, data memory depth in 32-bit words; fixed by the 6-bit address.

Ports:
- CLK  input  1  clock; all state updates on negedge CLK.
- nRST  input  1  reset, asynchronous, active-low.
- WB_EXMEM  input  1  load: read memory and write back to register rw.
- M_EXMEM  input  1  store: write Data_EXMEM to memory.
- Address_EXMEM  input  6  word address.
- Data_EXMEM  input  32  store data.
- rw_EXMEM  input  5  destination register of a load.
- ForwardCtrl_EXMEM  input  1  result is forwardable.
- WB_MEMWB  output  1  register write enable to write-back.
- rw_MEMWB  output  5  destination register.
- Data_MEMWB  output  32  loaded data.
- ForwardCtrl_MEMWB  output  1  forward-valid for the forwarding unit.
- Stall_MEM  output  1  freeze IF/ID/EX and EX/MEM; combinational.

Behaviour:
- Reset (nRST=0, asynchronous):
  - All MEM/WB outputs go to 0; FSM goes to IDLE; wait counter goes to 0.
  - All 64 memory words are cleared to 0.
  - Stall_MEM = 0.
- Operation decode, evaluated in the current cycle:
  - M_EXMEM=1: store. If WB_EXMEM is also 1, the op is still treated as a store and no write-back occurs.
  - M_EXMEM=0 and WB_EXMEM=1: load.
  - Both 0: bubble.
- FSM states IDLE and BUSY. Counter cnt is 4 bits.
- IDLE with a bubble:
  - At the next negedge, the MEM/WB register captures WB=0, rw=0, Data=0, ForwardCtrl=0.
- IDLE with a load or store and MEM_LAT=0 (completion edge):
  - The op completes at the next negedge.
  - Store: mem[Address] <= Data_EXMEM. MEM/WB captures a bubble.
  - Load: Data_MEMWB <= mem[Address] (value before any same-edge write, of which there is none), rw_MEMWB <= rw_EXMEM, ForwardCtrl_MEMWB <= ForwardCtrl_EXMEM.
  - WB_MEMWB <= 1 only if rw_EXMEM != 0; a load to $0 never asserts WB_MEMWB or ForwardCtrl_MEMWB.
- IDLE with a load or store and MEM_LAT>0:
  - Stall_MEM = 1 combinationally.
  - At the next negedge: state goes to BUSY, cnt <= MEM_LAT-1, MEM/WB captures a bubble.
- BUSY:
  - Inputs must be held stable by upstream, which is frozen by Stall_MEM.
  - cnt!=0: Stall_MEM = 1. At the negedge, cnt decrements and MEM/WB captures a bubble.
  - cnt==0: Stall_MEM = 0. At the negedge, the completion-edge actions from the MEM_LAT=0 case are performed and state returns to IDLE.
- Latency and occupancy:
  - Total occupancy per load or store is MEM_LAT+1 cycles.
  - Stall_MEM is high for exactly MEM_LAT of those cycles.
  - Load data appears on Data_MEMWB after the final edge.
- Memory writes happen only on the completion edge.
  - Reset during BUSY aborts the access with no memory write; memory is cleared anyway.
- Back-to-back ops:
  - A load immediately following a store to the same address returns the stored value, since the write completed at an earlier edge.
  - An op presented on the cycle after completion starts a fresh IDLE evaluation.
- Address wrap is impossible: 6 bits covers DEPTH=64 exactly.

Test Plan:
- Reset, then load from address 0x05 to rw=3 (MEM_LAT=0) -> after 1 negedge: WB_MEMWB=1, rw_MEMWB=3, Data_MEMWB=0x00000000, Stall_MEM=0 throughout.
- MEM_LAT=0: store 0xDEADBEEF to 0x3F, then load 0x3F to rw=7 on the next cycle -> Data_MEMWB=0xDEADBEEF, WB_MEMWB=1, ForwardCtrl_MEMWB follows input.
- MEM_LAT=2: load 0x10 after a store of 0x12345678 to 0x10 -> Stall_MEM high for 2 cycles, two bubbles on MEM/WB, data 0x12345678 valid after the 3rd negedge.
- Load to rw=0 with ForwardCtrl_EXMEM=1 -> WB_MEMWB=0, ForwardCtrl_MEMWB=0. WB=1 and M=1 with Data 0xA5A5A5A5 at 0x01 -> memory written, WB_MEMWB=0.
- MEM_LAT=3: store 0xCAFEF00D to 0x20, pulse nRST low mid-BUSY -> outputs 0 immediately, Stall_MEM=0; a subsequent load of 0x20 returns 0x00000000.
- A stream of bubbles -> WB_MEMWB, ForwardCtrl_MEMWB and Stall_MEM stay 0, and memory is unchanged (a spot-check read of 0x3F returns its prior value).
